// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signals of the transmit arbiter.
// master drives requests; slave is the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   last;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         tx_data;
  logic               tx_strobe;
  logic               busy;
  logic [2:0]         grant_id;

  modport master (
    output req, last, data,
    input  ack, tx_data, tx_strobe, busy, grant_id
  );

  modport slave (
    input  req, last, data,
    output ack, tx_data, tx_strobe, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte path between N_REQ
// producers, with strobe pacing and grant locking across multi-byte messages.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 12500,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [7:0]             byte_q, byte_d;
  logic                   last_q, last_d;
  logic                   locked_q, locked_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic [N_REQ-1:0][7:0]  bytes;
  logic                   pick_vld;
  logic [IW-1:0]          pick;
  logic                   own_req;
  logic                   strobe;

  assign bytes   = bus.data;
  assign own_req = bus.req[grant_q];

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % N_REQ);
  endfunction

  // First requester strictly after the previous owner, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_vld && bus.req[rr_idx(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick     = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    byte_d   = byte_q;
    last_d   = last_q;
    locked_d = locked_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          ptr_d   = pick;
          byte_d  = bytes[pick];
          last_d  = bus.last[pick];
          state_d = SEND;
        end
      end
      SEND: begin
        locked_d = !last_q;
        gap_d    = GW'(GAP_CYCLES - 2);
        tmo_d    = '0;
        state_d  = GAP;
      end
      GAP: begin
        // A locked owner already holding req skips the HOLD cycle so
        // back-to-back message bytes land exactly GAP_CYCLES apart.
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (!locked_q) begin
          state_d = IDLE;
        end else if (own_req) begin
          byte_d  = bytes[grant_q];
          last_d  = bus.last[grant_q];
          state_d = SEND;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (own_req) begin
          byte_d  = bytes[grant_q];
          last_d  = bus.last[grant_q];
          tmo_d   = '0;
          state_d = SEND;
        end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
          tmo_d    = '0;
          locked_d = 1'b0;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= IW'(N_REQ - 1);
      byte_q   <= '0;
      last_q   <= 1'b0;
      locked_q <= 1'b0;
      gap_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      locked_q <= locked_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
    end
  end

  // Outputs decode registered state only; req never reaches ack combinationally.
  assign strobe = (state_q == SEND);

  for (genvar i = 0; i < N_REQ; i++) begin : g_ack
    assign bus.ack[i] = strobe && (grant_q == IW'(i));
  end

  assign bus.tx_strobe = strobe;
  assign bus.tx_data   = byte_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_id  = 3'(grant_q);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table-driven single requests,
// scoreboarded byte delivery, round robin, lock, timeout, reset, random pacing.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int TMO = 20;

  typedef struct {
    int         id;
    logic [7:0] b;
    logic [3:0] exp_ack;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus();

  uart_tx_arbiter #(
    .N_REQ(N), .GAP_CYCLES(GAP), .LOCK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [N][$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_cyc = -1, n_strobe = 0;
  bit         saw;
  int         sgid, sdist;
  logic [7:0] sdata;
  logic [3:0] sack;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lim);
    n_cmp++;
    if (act < lim) begin
      n_bad++;
      $display("FAIL %s: got %0d, required >= %0d (cycle %0d)", name, act, lim, cyc);
    end
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        e = src_q[i][0];
        bus.req[i]          = 1'b1;
        bus.last[i]         = e[8];
        bus.data[8*i +: 8]  = e[7:0];
      end else begin
        bus.req[i]  = 1'b0;
        bus.last[i] = 1'b0;
      end
    end
  endtask

  task automatic send(input int id, input logic [7:0] b, input logic l);
    src_q[id].push_back({l, b});
    exp_q[id].push_back(b);
    drive();
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  // One clock: sample just after the edge, score any strobe, re-drive requests.
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    cyc++;
    saw = 1'b0;
    if (bus.tx_strobe) begin
      saw   = 1'b1;
      sgid  = int'(bus.grant_id);
      sdata = bus.tx_data;
      sack  = bus.ack;
      n_strobe++;
      chk("ack_onehot", int'(bus.ack), 1 << sgid);
      sdist = (last_cyc < 0) ? -1 : cyc - last_cyc;
      if (last_cyc >= 0) chk_ge("pacing", sdist, GAP);
      last_cyc = cyc;
      if (sgid < N) begin
        chk("strobe_expected", int'(exp_q[sgid].size() != 0), 1);
        if (exp_q[sgid].size() != 0) begin
          e = exp_q[sgid].pop_front();
          chk("sb_data", int'(bus.tx_data), int'(e));
        end
        if (src_q[sgid].size() != 0) void'(src_q[sgid].pop_front());
      end else begin
        chk("grant_range", sgid, 0);
      end
    end else begin
      chk("ack_quiet", int'(bus.ack), 0);
    end
    drive();
  endtask

  task automatic wait_strobe(input string name, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step();
      ok = saw;
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step();
      ok = !bus.busy;
    end
    chk("idle_reached", int'(ok), 1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   n0;
    bus.req  = '0;
    bus.last = '0;
    bus.data = '0;
    vt[0] = '{2, 8'h41, 4'b0100};
    vt[1] = '{0, 8'hA5, 4'b0001};
    vt[2] = '{3, 8'h7E, 4'b1000};
    vt[3] = '{1, 8'h00, 4'b0010};
    vt[4] = '{3, 8'hFF, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",       int'(bus.ack), 0);
    chk("rst_tx_strobe", int'(bus.tx_strobe), 0);
    chk("rst_tx_data",   int'(bus.tx_data), 0);
    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_grant_id",  int'(bus.grant_id), 0);
    reset = 1'b1;
    step();

    // Single requests: grant, data, ack, busy falling GAP cycles after strobe.
    for (int v = 0; v < 5; v++) begin
      send(vt[v].id, vt[v].b, 1'b1);
      wait_strobe("tbl_strobe", 10);
      chk("tbl_grant", sgid, vt[v].id);
      chk("tbl_data", int'(sdata), int'(vt[v].b));
      chk("tbl_ack", int'(sack), int'(vt[v].exp_ack));
      repeat (GAP - 1) step();
      chk("tbl_busy_gap", int'(bus.busy), 1);
      step();
      chk("tbl_busy_drop", int'(bus.busy), 0);
      chk("tbl_tx_hold", int'(bus.tx_data), int'(vt[v].b));
      chk("tbl_grant_hold", int'(bus.grant_id), vt[v].id);
      step();
    end

    // All four requesting twice each: order 0..3 repeated, IDLE spacing.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        send(i, 8'(8'h10 + 16 * r + i), 1'b1);
    for (int k = 0; k < 2 * N; k++) begin
      wait_strobe("rr_strobe", 20);
      chk("rr_order", sgid, k % N);
      if (k > 0) chk("rr_spacing", sdist, GAP + 1);
    end
    wait_idle(20);

    // Locked three-byte message from 1 while 0 waits.
    send(1, "A", 1'b0);
    send(1, "B", 1'b0);
    send(1, "C", 1'b1);
    wait_strobe("lock_a", 10);
    chk("lock_a_id", sgid, 1);
    send(0, 8'h30, 1'b1);
    wait_strobe("lock_b", 20);
    chk("lock_b_id", sgid, 1);
    chk("lock_b_data", int'(sdata), int'("B"));
    chk("lock_b_gap", sdist, GAP);
    wait_strobe("lock_c", 20);
    chk("lock_c_id", sgid, 1);
    chk("lock_c_gap", sdist, GAP);
    wait_strobe("lock_next", 20);
    chk("lock_next_id", sgid, 0);
    chk("lock_next_gap", sdist, GAP + 1);
    wait_idle(20);

    // Lock held by 3 with no follow-up byte: 1 waits out the timeout.
    send(3, 8'h55, 1'b0);
    wait_strobe("tmo_first", 10);
    chk("tmo_first_id", sgid, 3);
    send(1, 8'h66, 1'b1);
    wait_strobe("tmo_release", 80);
    chk("tmo_release_id", sgid, 1);
    chk("tmo_release_gap", sdist, GAP + TMO + 1);
    wait_idle(20);

    // Async reset during GAP of a locked message.
    send(2, 8'h77, 1'b0);
    wait_strobe("rst_mid_strobe", 10);
    chk("rst_mid_id", sgid, 2);
    repeat (3) step();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_busy",   int'(bus.busy), 0);
    chk("rst_mid_strobe_lo", int'(bus.tx_strobe), 0);
    chk("rst_mid_ack",    int'(bus.ack), 0);
    chk("rst_mid_data",   int'(bus.tx_data), 0);
    chk("rst_mid_grant",  int'(bus.grant_id), 0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    last_cyc = -1;
    send(3, 8'h33, 1'b1);
    send(0, 8'h03, 1'b1);
    step();
    step();
    reset = 1'b1;
    wait_strobe("post_rst_first", 10);
    chk("post_rst_first_id", sgid, 0);
    wait_strobe("post_rst_second", 20);
    chk("post_rst_second_id", sgid, 3);
    wait_idle(20);

    // Random traffic: every byte delivered once, pacing checked per strobe.
    n0 = n_strobe;
    for (int n = 0; n < 100; n++) begin
      send(int'($urandom_range(0, N - 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 12)) step();
    end
    for (int k = 0; k < 20000 && pending() > 0; k++) step();
    chk("rand_drain_left", pending(), 0);
    chk("rand_strobe_count", n_strobe - n0, 100);
    wait_idle(2 * TMO + 4 * GAP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
